// File: rtl/lieat_axi_rd_pkg.sv
// Shared FSM encodings and response codes for the refill read responder.
package lieat_axi_rd_pkg;

    localparam int unsigned ST_W     = 6;
    localparam int unsigned IDLE_B   = 0;
    localparam int unsigned WAIT_B   = 1;
    localparam int unsigned RD_LO_B  = 2;
    localparam int unsigned RD_HI_B  = 3;
    localparam int unsigned CAP_B    = 4;
    localparam int unsigned RESP_B   = 5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 6'b000001,
        ST_WAIT  = 6'b000010,
        ST_RD_LO = 6'b000100,
        ST_RD_HI = 6'b001000,
        ST_CAP   = 6'b010000,
        ST_RESP  = 6'b100000
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/lieat_axi_rd_slave_if.sv
// AR/R channel bundle; rresp exists only with LIEAT_AXI_RD_SLAVE_DECERR_EN.
interface lieat_axi_rd_slave_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [63:0]     rdata;
    logic            rvalid;
    logic            rready;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
    logic [1:0]      rresp;
`endif

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rvalid
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
        , input rresp
`endif
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rvalid
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
        , output rresp
`endif
    );
endinterface

// File: rtl/lieat_axi_rd_reqbuf.sv
// One-entry valid/ready request buffer; holds the address (and range-error bit
// when LIEAT_AXI_RD_SLAVE_DECERR_EN is defined).
module lieat_axi_rd_reqbuf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic            pop,
    output logic            buf_valid,
    output logic [XLEN-1:0] buf_addr
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
    , input  logic          in_err
    , output logic          buf_err
`endif
);

    logic push;

    assign in_ready = ~buf_valid;
    assign push     = in_valid & in_ready;

    // Pop clears, push (which cannot coincide with a pop) loads afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
            buf_err   <= 1'b0;
`endif
        end else begin
            if (pop) buf_valid <= 1'b0;
            if (push) begin
                buf_valid <= 1'b1;
                buf_addr  <= in_addr;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
                buf_err   <= in_err;
`endif
            end
        end
    end

endmodule

// File: rtl/lieat_axi_rd_slave.sv
// Single-beat 64-bit read responder over a 32-bit, 1-cycle-latency SRAM.
// Optional macro LIEAT_AXI_RD_SLAVE_DECERR_EN adds rresp and out-of-range DECERR.
module lieat_axi_rd_slave
    import lieat_axi_rd_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     MEM_AW   = 16,
    parameter logic [XLEN-1:0] MEM_BASE = 32'h8000_0000,
    parameter int unsigned     LATENCY  = 0
) (
    input  logic              clock,
    input  logic              reset,
    lieat_axi_rd_slave_if.slave axi,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned      CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_e            state;
    logic              buf_valid;
    logic [XLEN-1:0]   buf_addr;
    logic [XLEN-1:0]   buf_off;
    logic [MEM_AW-1:0] buf_widx;
    logic              start_err;
    logic              pop;
    logic [MEM_AW-1:0] act_widx;
    logic              act_err;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       rdata;
    logic              rvalid;

`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
    localparam logic [XLEN:0] LIMIT = {1'b0, MEM_BASE} + ((XLEN+1)'(1) << (MEM_AW + 2));
    logic       ar_err;
    logic       buf_err;
    logic [1:0] rresp;

    assign ar_err    = (axi.araddr < MEM_BASE) || ({1'b0, axi.araddr} >= LIMIT);
    assign start_err = buf_err;
    assign axi.rresp = rresp;
`else
    assign start_err = 1'b0;
`endif

    lieat_axi_rd_reqbuf #(.XLEN(XLEN)) u_reqbuf (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (axi.arvalid),
        .in_ready  (axi.arready),
        .in_addr   (axi.araddr),
        .pop       (pop),
        .buf_valid (buf_valid),
        .buf_addr  (buf_addr)
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
        , .in_err  (ar_err)
        , .buf_err (buf_err)
`endif
    );

    // Word index of the buffered request relative to the SRAM base.
    assign buf_off  = buf_addr - MEM_BASE;
    assign buf_widx = MEM_AW'(buf_off >> 2);

    // Pop from IDLE, or straight out of RESP on the R handshake (no IDLE bubble).
    assign pop = buf_valid & (state[IDLE_B] | (state[RESP_B] & axi.rready));

    assign axi.rvalid = rvalid;
    assign axi.rdata  = rdata;

    // Sequencer: state, SRAM strobes and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            act_widx <= '0;
            act_err  <= 1'b0;
            cnt      <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            mem_ren  <= 1'b0;
            mem_addr <= '0;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
            rresp    <= RESP_OKAY;
`endif
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (act_err) begin
                            state  <= ST_RESP;
                            rvalid <= 1'b1;
                            rdata  <= '0;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
                            rresp  <= RESP_DECERR;
`endif
                        end else begin
                            state    <= ST_RD_LO;
                            mem_ren  <= 1'b1;
                            mem_addr <= act_widx;
                        end
                    end
                end
                ST_RD_LO: begin
                    state    <= ST_RD_HI;
                    mem_addr <= act_widx + MEM_AW'(1);
                end
                ST_RD_HI: begin
                    state       <= ST_CAP;
                    mem_ren     <= 1'b0;
                    rdata[31:0] <= mem_rdata;
                end
                ST_CAP: begin
                    state        <= ST_RESP;
                    rdata[63:32] <= mem_rdata;
                    rvalid       <= 1'b1;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
                    rresp        <= RESP_OKAY;
`endif
                end
                ST_RESP: begin
                    if (axi.rready) begin
                        state  <= ST_IDLE;
                        rvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                act_widx <= buf_widx;
                act_err  <= start_err;
                cnt      <= LAT_C;
                if (LATENCY != 0) begin
                    state <= ST_WAIT;
                end else if (start_err) begin
                    state  <= ST_RESP;
                    rvalid <= 1'b1;
                    rdata  <= '0;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
                    rresp  <= RESP_DECERR;
`endif
                end else begin
                    state    <= ST_RD_LO;
                    mem_ren  <= 1'b1;
                    mem_addr <= buf_widx;
                end
            end
        end
    end

endmodule

// File: tb/tb_lieat_axi_rd_slave.sv
// Scoreboard bench: two DUTs (LATENCY 0 and 3) sharing one SRAM image.
module tb_lieat_axi_rd_slave;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    lieat_axi_rd_slave_if #(.XLEN(32)) if0 ();
    lieat_axi_rd_slave_if #(.XLEN(32)) if1 ();

    logic        mem_ren0, mem_ren1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [31:0] mem_rdata0, mem_rdata1;
    logic [31:0] mem [0:65535];

    lieat_axi_rd_slave #(.LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .axi(if0),
        .mem_ren(mem_ren0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
    );
    lieat_axi_rd_slave #(.LATENCY(3)) dut1 (
        .clock(clock), .reset(reset), .axi(if1),
        .mem_ren(mem_ren1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1)
    );

    // Synchronous SRAM models, 1-cycle read latency.
    always @(posedge clock) begin
        if (mem_ren0) mem_rdata0 <= mem[mem_addr0];
        if (mem_ren1) mem_rdata1 <= mem[mem_addr1];
    end

    typedef logic [65:0] exp_t;
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic exp_t got_of(input int d);
        logic [1:0] rr;
`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
        rr = (d == 1) ? if1.rresp : if0.rresp;
`else
        rr = 2'b00;
`endif
        return {rr, (d == 1) ? if1.rdata : if0.rdata};
    endfunction

    // Monitors: pop and compare on every R handshake.
    always @(negedge clock) begin
        if (!reset && if0.rvalid && if0.rready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected response: got %h, required none", if0.rdata);
            end else chk("dut0 response", got_of(0), q0.pop_front());
        end
        if (!reset && if1.rvalid && if1.rready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected response: got %h, required none", if1.rdata);
            end else chk("dut1 response", got_of(1), q1.pop_front());
        end
    end

    task automatic send(input int d, input logic [31:0] a, output int acyc);
        bit ok = 0;
        acyc = 0;
        @(posedge clock); #1;
        if (d == 1) begin if1.arvalid = 1'b1; if1.araddr = a; end
        else        begin if0.arvalid = 1'b1; if0.araddr = a; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ((d == 1) ? if1.arready : if0.arready) begin acyc = cyc; ok = 1; break; end
        end
        @(posedge clock); #1;
        if (d == 1) if1.arvalid = 1'b0; else if0.arvalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar timeout dut%0d: got no arready, required arready", d);
        end
    endtask

    task automatic wait_resp(input int d, input int acyc, output int lat, output int nren,
                             output int first_ren, output logic [15:0] a0, output logic [15:0] a1);
        lat = -1; nren = 0; first_ren = -1; a0 = '0; a1 = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((d == 1) ? mem_ren1 : mem_ren0) begin
                if (nren == 0) begin a0 = (d == 1) ? mem_addr1 : mem_addr0; first_ren = cyc - acyc; end
                else if (nren == 1) a1 = (d == 1) ? mem_addr1 : mem_addr0;
                nren++;
            end
            if ((d == 1) ? if1.rvalid : if0.rvalid) begin lat = cyc - acyc; break; end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL rvalid timeout dut%0d: got no rvalid, required rvalid", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acyc, lat, nren, fren, bad, blk, ta, gap;
        logic [15:0] a0, a1;

        for (int i = 0; i < 65536; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        if0.arvalid = 0; if0.araddr = '0; if0.rready = 1;
        if1.arvalid = 0; if1.araddr = '0; if1.rready = 1;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst arready", 66'(if0.arready), 66'd1);
        chk("rst rvalid",  66'(if0.rvalid),  66'd0);
        chk("rst rdata",   66'(if0.rdata),   66'd0);
        chk("rst mem_ren", 66'(mem_ren0),    66'd0);
        chk("rst mem_addr", 66'(mem_addr0),  66'd0);
        @(posedge clock); #1 reset = 0;

        // Basic read, LATENCY=0
        q0.push_back({2'b00, 64'h0010_0093_0000_0013});
        send(0, 32'h8000_0000, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("lat0 latency", 66'(lat), 66'd5);
        chk("lat0 reads", 66'(nren), 66'd2);
        chk("lat0 addr lo", 66'(a0), 66'h0000);
        chk("lat0 addr hi", 66'(a1), 66'h0001);
        repeat (2) @(posedge clock);

        // Stall in RESP; one more AR buffered, the next blocked
        #1 if0.rready = 0;
        q0.push_back({2'b00, 64'hC0DE_0003_C0DE_0002});
        send(0, 32'h8000_0008, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("stall latency", 66'(lat), 66'd5);
        q0.push_back({2'b00, 64'hC0DE_0005_C0DE_0004});
        send(0, 32'h8000_0010, acyc);
        #1 if0.arvalid = 1; if0.araddr = 32'h8000_0020;
        bad = 0; blk = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!if0.rvalid || if0.rdata !== 64'hC0DE_0003_C0DE_0002) bad++;
            if (if0.arready) blk++;
        end
        chk("stall hold", 66'(bad), 66'd0);
        chk("third ar blocked", 66'(blk), 66'd0);
        @(posedge clock); #1 if0.arvalid = 0; if0.rready = 1;
        @(negedge clock);
        ta = cyc;
        gap = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (if0.rvalid) begin gap = cyc - ta; break; end
        end
        chk("back-to-back gap", 66'(gap), 66'd4);
        repeat (2) @(posedge clock);

        // Wrap of the high word to SRAM word 0
        q0.push_back({2'b00, 64'h0000_0013_C0DE_FFFF});
        send(0, 32'h8003_FFFC, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("wrap reads", 66'(nren), 66'd2);
        chk("wrap addr lo", 66'(a0), 66'hFFFF);
        chk("wrap addr hi", 66'(a1), 66'h0000);
        repeat (2) @(posedge clock);

        // LATENCY=3 instance
        q1.push_back({2'b00, 64'hC0DE_0002_0010_0093});
        send(1, 32'h8000_0004, acyc);
        wait_resp(1, acyc, lat, nren, fren, a0, a1);
        chk("lat3 latency", 66'(lat), 66'd8);
        chk("lat3 first ren", 66'(fren), 66'd5);
        chk("lat3 reads", 66'(nren), 66'd2);
        repeat (2) @(posedge clock);

        // Reset pulse during RD_HI (second read strobe); response discarded
        send(0, 32'h8000_0018, acyc);
        nren = 0;
        for (int i = 0; i < 20 && nren < 2; i++) begin
            @(negedge clock);
            if (mem_ren0) nren++;
        end
        chk("rdhi reached", 66'(nren), 66'd2);
        reset = 1;
        #2;
        chk("midrst arready", 66'(if0.arready), 66'd1);
        chk("midrst rvalid",  66'(if0.rvalid),  66'd0);
        chk("midrst rdata",   66'(if0.rdata),   66'd0);
        chk("midrst mem_ren", 66'(mem_ren0),    66'd0);
        @(posedge clock); #1 reset = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (if0.rvalid) bad++;
        end
        chk("no stale resp", 66'(bad), 66'd0);
        q0.push_back({2'b00, 64'h0010_0093_0000_0013});
        send(0, 32'h8000_0000, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("post-rst latency", 66'(lat), 66'd5);
        repeat (2) @(posedge clock);

`ifdef LIEAT_AXI_RD_SLAVE_DECERR_EN
        // Out-of-range requests: DECERR without SRAM access
        q0.push_back({2'b11, 64'h0});
        send(0, 32'h0000_1000, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("decerr low reads", 66'(nren), 66'd0);
        chk("decerr low latency", 66'(lat), 66'd2);
        repeat (2) @(posedge clock);
        q0.push_back({2'b00, 64'h0010_0093_0000_0013});
        send(0, 32'h8000_0000, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("okay after decerr reads", 66'(nren), 66'd2);
        repeat (2) @(posedge clock);
        q0.push_back({2'b11, 64'h0});
        send(0, 32'h8004_0000, acyc);
        wait_resp(0, acyc, lat, nren, fren, a0, a1);
        chk("decerr high reads", 66'(nren), 66'd0);
        repeat (2) @(posedge clock);
`endif

        repeat (4) @(negedge clock);
        chk("q0 drained", 66'(q0.size()), 66'd0);
        chk("q1 drained", 66'(q1.size()), 66'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
